// File: rtl/counter_seq_pkg.sv
// Shared types for the counter mode sequencer.
// Mode codes, FSM states and the stored step record.
package counter_seq_pkg;

  localparam logic [2:0] CTRL_UP     = 3'd0;
  localparam logic [2:0] CTRL_DOWN   = 3'd1;
  localparam logic [2:0] CTRL_UPDOWN = 3'd2;
  localparam logic [2:0] CTRL_LOAD   = 3'd3;
  localparam logic [2:0] CTRL_HOLD   = 3'd4;

  // Widest supported step duration; narrower fields are zero-extended.
  localparam int SEQ_DUR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [2:0]           ctrl;
    logic [3:0]           data;
    logic [SEQ_DUR_W-1:0] dur;
  } step_t;

endpackage

// File: rtl/counter_mode_sequencer_tick_divider.sv
// Free-running clk divider producing a registered one-cycle tick.
// The tick is high during the cycle in which the count sits at TICK_DIV-1.
module tick_divider #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int DW = $clog2(TICK_DIV);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      cnt  <= (cnt == DW'(TICK_DIV - 1)) ? '0 : cnt + DW'(1);
      tick <= (cnt == DW'(TICK_DIV - 2));
    end
  end

endmodule

// File: rtl/counter_mode_sequencer.sv
// Steps the mode counter through a stored program of
// {mode, load value, duration} entries on a slow tick.
module counter_mode_sequencer
  import counter_seq_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int STEPS    = 8,
  parameter int DUR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [$clog2(STEPS)-1:0] prog_addr,
  input  logic [2:0]               prog_ctrl,
  input  logic [3:0]               prog_data,
  input  logic [DUR_W-1:0]         prog_dur,
  input  logic [$clog2(STEPS):0]   prog_len,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic [2:0]               ctrl_out,
  output logic [3:0]               data_out,
  output logic                     tick
);

  localparam int IW = $clog2(STEPS);
  localparam int LW = IW + 1;

  step_t                mem [STEPS];
  seq_state_t           state, state_n;
  logic [IW-1:0]        idx, idx_n, nxt;
  logic [SEQ_DUR_W-1:0] rem, rem_n;
  logic [LW-1:0]        len;
  logic                 last;
  logic                 tick_q;
  logic                 clr;

  assign len  = (prog_len > LW'(STEPS)) ? LW'(STEPS) : prog_len;
  assign nxt  = idx + IW'(1);
  assign last = ({1'b0, idx} + LW'(1)) >= len;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < STEPS; i++)
        mem[i] <= '{ctrl: CTRL_HOLD, data: 4'd0, dur: '0};
    end else if (prog_we && state == IDLE) begin
      mem[prog_addr] <= '{ctrl: prog_ctrl,
                          data: prog_data,
                          dur:  SEQ_DUR_W'(prog_dur)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      rem   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      rem   <= rem_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    rem_n   = rem;
    unique case (state)
      IDLE: begin
        if (start && !stop && len != '0) begin
          state_n = RUN;
          idx_n   = '0;
          rem_n   = mem[0].dur;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          idx_n   = '0;
        end else if (tick_q) begin
          // A remaining count of 0 or 1 both end the step here.
          if (rem > SEQ_DUR_W'(1)) begin
            rem_n = rem - SEQ_DUR_W'(1);
          end else if (!last) begin
            idx_n = nxt;
            rem_n = mem[nxt].dur;
          end else if (loop_en) begin
            idx_n = '0;
            rem_n = mem[0].dur;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // Divider only counts across RUN->RUN edges; any exit drops a pending tick.
  assign clr = !(state == RUN && state_n == RUN);

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .en    (state == RUN),
    .clear (clr),
    .tick  (tick_q)
  );

  assign tick     = tick_q;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE) && !stop;
  assign step_idx = idx;
  assign ctrl_out = (state == RUN) ? mem[idx].ctrl : CTRL_HOLD;
  assign data_out = (state == RUN) ? mem[idx].data : 4'd0;

endmodule
